inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  IF stage: front end for the branch-redirect interface driven by the ID stage.
//  - Keeps the fetch PC and reads each 32-bit instruction as 4 little-endian bytes over a shared byte-wide memory port.
//  - Holds the assembled instruction for the IF/ID register.
//  - Redirects to branch_target_i when ID raises branch_flag_i.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  ADDR_W     32             PC / memory address width (InstAddrBus)
// PORTS
//  clk              in   1       single clock, rising edge
//  rst              in   1       synchronous, active-high reset (RstEnable = 1)
//  stall_i          in   1       downstream stall (ID stallFlag / pipeline control); 1 = hold
//  branch_flag_i    in   1       redirect request from ID (branchFlag)
//  branch_target_i  in   ADDR_W  redirect PC from ID (branchTarget)
//  mem_re_o         out  1       byte read request to memory arbiter
//  mem_addr_o       out  ADDR_W  byte address of the request
//  mem_grant_i      in   1       arbiter accepted the request this cycle
//  mem_rdata_i      in   8       read byte, valid the cycle after a grant
//  pc_o             out  ADDR_W  PC of inst_o
//  inst_o           out  32      assembled instruction
//  inst_valid_o     out  1       inst_o/pc_o valid; consumed when inst_valid_o & !stall_i
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//  - fetch_pc=RESET_PC; req_cnt=resp_cnt=0; pending=0; state=FETCH.
//  - inst_o=0, inst_valid_o=0, pc_o=RESET_PC.
//  - mem_re_o=0 combinationally while rst=1.
//  State FETCH:
//  - mem_re_o=1 while req_cnt<4 and branch_flag_i=0.
//  - mem_addr_o=fetch_pc+req_cnt, mod 2^ADDR_W.
//  - Grant (mem_re_o & mem_grant_i): req_cnt++; pending<=1, else pending<=0.
//  - No grant: address held, no counter change.
//  - pending=1: mem_rdata_i written to buf[8*resp_cnt +: 8]; resp_cnt++.
//  - Byte capture with resp_cnt==3: inst_o<=assembled word, pc_o<=fetch_pc, inst_valid_o<=1, state->HOLD.
//  State HOLD:
//  - mem_re_o=0; inst_o and pc_o held stable.
//  - stall_i=1: remain in HOLD.
//  - stall_i=0: handoff this cycle; fetch_pc<=fetch_pc+4 (wraps); counters cleared; inst_valid_o<=0; state->FETCH.
//  Latency / throughput:
//  - With grant always high, the first request is in cycle T and inst_valid_o is high in T+5.
//  - Next first request is the cycle after handoff, so 6 cycles per instruction with no stalls.
//  Redirect (branch_flag_i=1 at an edge, any state):
//  - fetch_pc<=branch_target_i; req_cnt=resp_cnt=0; pending<=0.
//  - inst_valid_o<=0; state->FETCH.
//  - Byte returned in the cycle after the redirect is discarded.
//  - mem_re_o=0 during the redirect cycle.
//  Priority: rst > branch_flag_i > stall_i > normal progress.
//  - Branch + stall in the same cycle: the redirect is taken.
//  - A branch held high across cycles re-redirects to the same target each cycle; this is harmless.
//  Misc:
//  - Any byte-aligned target is legal; there is no alignment check.
//  - Byte order is little-endian: the byte at addr+0 lands in inst_o[7:0].
//  - A consumer that sees branch_flag_i together with a handoff treats the instruction as squashed, via the IF/ID abort path.
// TESTING
//  1. Release reset; grant=1; mem[0..3]=13,05,10,00 -> mem_addr_o 0,1,2,3 in cycles 0-3; cycle 5: inst_o=32'h00100513, pc_o=0, inst_valid_o=1; next request addr 4.
//  2. grant=0 in cycles 1-2 of a fetch -> mem_addr_o stays 1 for 3 cycles; inst_valid_o 2 cycles later than test 1; word still 32'h00100513.
//  3. stall_i=1 for 3 cycles while valid -> inst_o/pc_o stable, mem_re_o=0; release -> one handoff, next addresses 4..7.
//  4. branch_flag_i=1, target=32'h1000, in the cycle of the 2nd grant -> stale byte dropped; next mem_addr_o=32'h1000; inst_o from 0x1000..0x1003, pc_o=32'h1000.
//  5. rst=1 after 2 bytes captured -> inst_valid_o=0 next cycle; in-flight byte ignored; fetch restarts at RESET_PC with 4 fresh bytes.
//  6. Redirect to 32'hFFFF_FFFE -> mem_addr_o FFFF_FFFE, FFFF_FFFF, 0, 1; pc_o=FFFF_FFFE; after handoff fetch_pc=32'h0000_0002.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles 32-bit little-endian instructions from a
// byte-wide memory port and presents them to the IF/ID register, with ID redirects.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_grant_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [2:0]        req_cnt_q, req_cnt_d;
    logic [1:0]        resp_cnt_q, resp_cnt_d;
    logic              pending_q, pending_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              mem_re_s;

    // Next-state logic: redirect beats stall, stall beats normal byte progress.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;
        pending_d  = 1'b0;
        buf_d      = buf_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        mem_re_s   = 1'b0;

        if (branch_flag_i) begin
            // A byte still in flight from before the redirect is dropped via pending.
            fetch_pc_d = branch_target_i;
            req_cnt_d  = 3'd0;
            resp_cnt_d = 2'd0;
            pending_d  = 1'b0;
            valid_d    = 1'b0;
            state_d    = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    mem_re_s = (req_cnt_q < 3'd4);
                    if (mem_re_s && mem_grant_i) begin
                        req_cnt_d = req_cnt_q + 3'd1;
                        pending_d = 1'b1;
                    end else begin
                        req_cnt_d = req_cnt_q;
                        pending_d = 1'b0;
                    end
                    if (pending_q) begin
                        resp_cnt_d = resp_cnt_q + 2'd1;
                        case (resp_cnt_q)
                            2'd0: buf_d[7:0]   = mem_rdata_i;
                            2'd1: buf_d[15:8]  = mem_rdata_i;
                            2'd2: buf_d[23:16] = mem_rdata_i;
                            default: begin
                                inst_d  = {mem_rdata_i, buf_q};
                                pc_d    = fetch_pc_q;
                                valid_d = 1'b1;
                                state_d = ST_HOLD;
                            end
                        endcase
                    end else begin
                        resp_cnt_d = resp_cnt_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        fetch_pc_d = fetch_pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                        req_cnt_d  = 3'd0;
                        resp_cnt_d = 2'd0;
                        valid_d    = 1'b0;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            req_cnt_q  <= 3'd0;
            resp_cnt_q <= 2'd0;
            pending_q  <= 1'b0;
            buf_q      <= 24'd0;
            inst_q     <= 32'd0;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            pending_q  <= pending_d;
            buf_q      <= buf_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_re_o     = mem_re_s & ~rst;
    assign mem_addr_o   = fetch_pc_q + {{(ADDR_W-3){1'b0}}, req_cnt_q};
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: an abstract fetch model pushes the
// expected (pc, word) pair; a negedge monitor pops and compares DUT outputs.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    inst_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_re_o        (mem_re_o),
        .mem_addr_o      (mem_addr_o),
        .mem_grant_i     (mem_grant_i),
        .mem_rdata_i     (mem_rdata_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: which PC is being fetched and how far along it is.
    logic [31:0] m_pc;
    int          m_nreq;
    int          m_ncap;
    logic        m_pend;
    logic        m_hold;
    logic        m_rst_state;
    logic        started = 1'b0;
    logic [63:0] exp_q[$];
    logic        exp_re;
    logic [31:0] exp_addr;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model across the edge just taken, using the inputs the DUT saw.
    task automatic model_step(output logic gnt, output logic [31:0] gaddr);
        gnt   = exp_re && mem_grant_i;
        gaddr = m_pc + 32'(m_nreq);
        if (rst) begin
            m_pc = RESET_PC; m_nreq = 0; m_ncap = 0; m_pend = 1'b0; m_hold = 1'b0;
            m_rst_state = 1'b1;
            exp_q.delete();
            exp_q.push_back({m_pc, mem_word(m_pc)});
        end else if (branch_flag_i) begin
            m_pc = branch_target_i; m_nreq = 0; m_ncap = 0; m_pend = 1'b0; m_hold = 1'b0;
            m_rst_state = 1'b0;
            exp_q.delete();
            exp_q.push_back({m_pc, mem_word(m_pc)});
        end else if (m_hold) begin
            if (!stall_i) begin
                m_pc = m_pc + 32'd4; m_nreq = 0; m_ncap = 0; m_pend = 1'b0; m_hold = 1'b0;
                exp_q.push_back({m_pc, mem_word(m_pc)});
            end
        end else begin
            if (m_pend) begin
                m_ncap++;
                if (m_ncap == 4) begin
                    m_hold = 1'b1;
                    m_rst_state = 1'b0;
                end
            end
            m_pend = gnt;
            if (gnt) m_nreq++;
        end
    endtask

    // Driver: directed bring-up (tests 1 and 6), then randomized traffic.
    initial begin
        logic        gnt;
        logic [31:0] gaddr;
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'd0;
        mem_grant_i = 1'b0; mem_rdata_i = 8'd0;
        exp_re = 1'b0; exp_addr = 32'd0;
        m_pc = RESET_PC; m_nreq = 0; m_ncap = 0; m_pend = 1'b0; m_hold = 1'b0; m_rst_state = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_step(gnt, gaddr);
            started = 1'b1;
            mem_rdata_i = gnt ? mem_byte(gaddr) : 8'($urandom);
            if (c < 2) begin
                rst = 1'b1; branch_flag_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b1;
            end else if (c < 16) begin
                rst = 1'b0; branch_flag_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b1;
            end else if (c == 16) begin
                branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
            end else if (c < 32) begin
                branch_flag_i = 1'b0; stall_i = (c >= 22 && c < 25); mem_grant_i = 1'b1;
            end else begin
                rst           = ($urandom_range(0, 199) == 0);
                branch_flag_i = ($urandom_range(0, 29) == 0);
                branch_target_i = ($urandom_range(0, 3) == 0)
                                ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
                stall_i       = ($urandom_range(0, 2) == 0);
                mem_grant_i   = ($urandom_range(0, 3) != 0);
            end
            exp_re   = !rst && !branch_flag_i && !m_hold && (m_nreq < 4);
            exp_addr = m_pc + 32'(m_nreq);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    logic [63:0] cur_exp;
    logic        seen = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            chk("mem_re", {31'd0, mem_re_o}, {31'd0, exp_re});
            if (exp_re) chk("mem_addr", mem_addr_o, exp_addr);
            chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_hold});
            if (m_hold && inst_valid_o) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL scoreboard: instruction presented with no expectation queued");
                        cur_exp = 64'd0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    seen = 1'b1;
                end
                chk("inst", inst_o, cur_exp[31:0]);
                chk("pc", pc_o, cur_exp[63:32]);
            end else begin
                seen = 1'b0;
            end
            if (m_rst_state && !m_hold) begin
                chk("reset_inst", inst_o, 32'd0);
                chk("reset_pc", pc_o, RESET_PC);
            end
        end
    end

endmodule
